// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_pkg
// Description : Shared constants for the 16-lane vector datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_pkg;

  localparam int VEC_LEN            = 16;
  localparam int IDX_WIDTH          = 4;
  localparam int DEFAULT_DATA_WIDTH = 15;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VEC_LEN - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vector_serialize_16_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_serialize_16_if
// Description : Parallel-vector capture and element-stream bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_serialize_16_if #(
  parameter int DATA_WIDTH = vector_pkg::DEFAULT_DATA_WIDTH
);
  import vector_pkg::*;

  logic                         inReady;
  logic signed [DATA_WIDTH-1:0] S [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] outData;
  logic                         outValid;
  logic [IDX_WIDTH-1:0]         outIndex;
  logic                         outLast;
  logic                         outAccept;
  logic                         canAccept;
  logic                         overflow;

  modport master (
    output inReady, S, outAccept,
    input  outData, outValid, outIndex, outLast, canAccept, overflow
  );

  modport slave (
    input  inReady, S, outAccept,
    output outData, outValid, outIndex, outLast, canAccept, overflow
  );

endinterface
`default_nettype wire

// File: rtl/vector_hold_buffer_16.sv
`default_nettype none
// ============================================================================
// Module      : vector_hold_buffer_16
// Description : 16-entry vector register bank, two load sources, indexed read.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_hold_buffer_16
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         sel_alt,
  input  logic signed [DATA_WIDTH-1:0] din  [VEC_LEN],
  input  logic signed [DATA_WIDTH-1:0] alt  [VEC_LEN],
  input  logic [IDX_WIDTH-1:0]         rd_idx,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic signed [DATA_WIDTH-1:0] dout [VEC_LEN]
);

  logic signed [DATA_WIDTH-1:0] mem_q [VEC_LEN];

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] mem_d;

    always_comb begin
      mem_d = mem_q[i];
      if (load) mem_d = sel_alt ? alt[i] : din[i];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_q[i] <= '0;
      else        mem_q[i] <= mem_d;
    end

    assign dout[i] = mem_q[i];
  end

  assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/vector_serialize_16.sv
`default_nettype none
// ============================================================================
// Module      : vector_serialize_16
// Description : Captures 16-lane vectors and streams them one element per
//               cycle, with an active plus pending buffer for bubble-free flow.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_serialize_16
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int VEC_LEN    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  vector_serialize_16_if.slave bus
);

  logic [0:0]                   state_q, state_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic                         pend_full_q, pend_full_d;
  logic                         ovf_q, ovf_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;

  logic                         act_load, act_from_pend, pend_load;
  logic                         xfer, last_xfer;
  logic signed [DATA_WIDTH-1:0] s_vec        [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] pend_vec     [VEC_LEN];
  // Parallel output of the active bank has no consumer.
  logic signed [DATA_WIDTH-1:0] act_vec_unused [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] act_rd, pend_rd;

  assign s_vec     = bus.S;
  assign xfer      = (state_q == ST_STREAM) && bus.outAccept;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  vector_hold_buffer_16 #(.DATA_WIDTH(DATA_WIDTH)) u_active (
    .clk     (clk),
    .reset   (reset),
    .load    (act_load),
    .sel_alt (act_from_pend),
    .din     (s_vec),
    .alt     (pend_vec),
    .rd_idx  (idx_d),
    .rd_data (act_rd),
    .dout    (act_vec_unused)
  );

  vector_hold_buffer_16 #(.DATA_WIDTH(DATA_WIDTH)) u_pending (
    .clk     (clk),
    .reset   (reset),
    .load    (pend_load),
    .sel_alt (1'b0),
    .din     (s_vec),
    .alt     (s_vec),
    .rd_idx  ('0),
    .rd_data (pend_rd),
    .dout    (pend_vec)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pend_full_d   = pend_full_q;
    ovf_d         = ovf_q;
    data_d        = data_q;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;

    if (enable) begin
      ovf_d = 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.inReady) begin
          act_load = 1'b1;
          idx_d    = '0;
          state_d  = ST_STREAM;
        end
      end else if (last_xfer) begin
        idx_d = '0;
        if (pend_full_q) begin
          // Pending drains into active; a coincident capture refills pending.
          act_load      = 1'b1;
          act_from_pend = 1'b1;
          pend_load     = bus.inReady;
          pend_full_d   = bus.inReady;
        end else if (bus.inReady) begin
          act_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        if (xfer) idx_d = idx_q + 1'b1;
        if (bus.inReady) begin
          if (!pend_full_q) begin
            pend_load   = 1'b1;
            pend_full_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      // Lane 0 of a freshly loaded vector bypasses the bank being written.
      if (act_load) data_d = act_from_pend ? pend_rd : s_vec[0];
      else          data_d = act_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
    end
  end

  assign bus.outData   = data_q;
  assign bus.outValid  = (state_q == ST_STREAM);
  assign bus.outIndex  = idx_q;
  assign bus.outLast   = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign bus.canAccept = !pend_full_q;
  assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_serialize_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_serialize_16
// Description : Bench for vector_serialize_16 against a queue-of-elements model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_serialize_16;
  import vector_pkg::*;

  localparam int DW = 15;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  vector_serialize_16_if #(.DATA_WIDTH(DW)) bus ();

  vector_serialize_16 #(.DATA_WIDTH(DW), .VEC_LEN(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: every element still owed to the consumer, in delivery order.
  int exp_q[$];
  bit exp_ovf;
  int vec[16];

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int s;
    int ei;
    s  = exp_q.size();
    ei = (s == 0) ? 0 : (16 - (s % 16)) % 16;
    chk("outValid", int'(bus.outValid), int'(s > 0));
    if (s > 0) begin
      chk("outIndex", int'(bus.outIndex), ei);
      chk("outData", int'(bus.outData), exp_q[0]);
      chk("outLast", int'(bus.outLast), int'(ei == 15));
    end else begin
      chk("outLast_idle", int'(bus.outLast), 0);
    end
    chk("canAccept", int'(bus.canAccept), int'(((s + 15) / 16) < 2));
    chk("overflow", int'(bus.overflow), int'(exp_ovf));
  endtask

  task automatic tick(bit ir, bit acc);
    bus.inReady   = ir;
    bus.outAccept = acc;
    for (int k = 0; k < 16; k++) bus.S[k] = DW'(vec[k]);
    @(posedge clk);
    if (enable) begin
      if (exp_q.size() > 0 && acc) void'(exp_q.pop_front());
      exp_ovf = 1'b0;
      if (ir) begin
        if (((exp_q.size() + 15) / 16) < 2) begin
          for (int k = 0; k < 16; k++) exp_q.push_back(vec[k]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic set_const(int v);
    for (int k = 0; k < 16; k++) vec[k] = v;
  endtask

  task automatic set_random();
    for (int k = 0; k < 16; k++) vec[k] = int'($urandom_range(32767, 0)) - 16384;
  endtask

  initial begin
    int run;
    int best;

    reset         = 1'b0;
    enable        = 1'b1;
    bus.inReady   = 1'b0;
    bus.outAccept = 1'b0;
    set_const(0);
    for (int k = 0; k < 16; k++) bus.S[k] = '0;
    exp_ovf = 1'b0;

    #12;
    chk("rst_outData", int'(bus.outData), 0);
    chk("rst_outIndex", int'(bus.outIndex), 0);
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Single ramp vector -8..7 at full accept.
    for (int k = 0; k < 16; k++) vec[k] = k - 8;
    tick(1'b1, 1'b1);
    chk("single_first_data", int'(bus.outData), -8);
    repeat (17) tick(1'b0, 1'b1);

    // Backpressure with accept pattern 1,0,0,1,0,0,...
    set_random();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) tick(1'b0, (i % 3) == 0);

    // Back-to-back vectors five cycles apart must stream without a gap.
    run  = 0;
    best = 0;
    for (int i = 0; i < 46; i++) begin
      if (i == 0) set_const(100);
      if (i == 5) set_const(-200);
      tick((i == 0) || (i == 5), 1'b1);
      if (i == 5) chk("b2b_canAccept_low", int'(bus.canAccept), 0);
      run  = bus.outValid ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    chk("b2b_valid_run", best, 32);

    // Three captures with the consumer stalled: third is dropped.
    set_const(1); tick(1'b1, 1'b0);
    set_const(2); tick(1'b1, 1'b0);
    set_const(3); tick(1'b1, 1'b0);
    chk("ovf_pulse", int'(bus.overflow), 1);
    tick(1'b0, 1'b0);
    repeat (34) tick(1'b0, 1'b1);

    // Capture on the same edge that lane 15 is accepted with pending full.
    set_const(10); tick(1'b1, 1'b0);
    set_const(11); tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b1);
    set_const(12); tick(1'b1, 1'b1);
    chk("edge_no_ovf", int'(bus.overflow), 0);
    chk("edge_pending_head", int'(bus.outData), 11);
    repeat (34) tick(1'b0, 1'b1);

    // Asynchronous reset in the middle of a vector.
    set_random();
    tick(1'b1, 1'b1);
    repeat (9) tick(1'b0, 1'b1);
    chk("pre_reset_index", int'(bus.outIndex), 9);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Enable low for four cycles freezes the stream and ignores captures.
    set_random();
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    enable = 1'b0;
    set_const(-5);
    repeat (4) tick(1'b1, 1'b1);
    chk("frozen_index", int'(bus.outIndex), 3);
    enable = 1'b1;
    repeat (20) tick(1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      set_random();
      tick(($urandom % 8) == 0, ($urandom % 4) != 0);
    end
    repeat (40) tick(1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
